// File: rtl/tlb_cache.sv
// tlb_cache: small fully-associative translation cache in front of the
// page-table walker. Lookups are answered combinationally on a hit. A miss
// starts a single walk request that is held stable until the walker
// answers. The returned 4 KiB page and its DAGUXWRV bits are then installed.
//
// State  | Meaning
// -------+-------------------------------------------------------------
// IDLE   | no walk outstanding; a miss latches miss_va and starts a walk
// WALK   | request held on the walker port; the response fills an entry
// DRAIN  | flushed during a walk; wait for the response and discard it
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   lookup_valid/addr     translation request (virtual address)
//   lookup_hit/paddr/perms translation result, all zero on a miss
//   busy                  walk outstanding
//   flush                 invalidate all entries
//   mmu_req_valid/addr    walk request towards the walker
//   mmu_resp_valid/addr/perms  walker result (page address and leaf perms)
module tlb_cache #(
    parameter int ENTRIES = 8,
    localparam int IDXW = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [63:0] lookup_addr,
    output logic        lookup_hit,
    output logic [63:0] lookup_paddr,
    output logic [7:0]  lookup_perms,
    output logic        busy,
    input  logic        flush,
    output logic        mmu_req_valid,
    output logic [63:0] mmu_req_addr,
    input  logic        mmu_resp_valid,
    input  logic [63:0] mmu_resp_addr,
    input  logic [7:0]  mmu_resp_perms
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [ENTRIES-1:0] valid;
    logic [35:0]        vpn   [ENTRIES];
    logic [51:0]        ppn   [ENTRIES];
    logic [7:0]         perms [ENTRIES];
    logic [IDXW-1:0]    rr_ptr;
    logic [63:0]        miss_va;

    logic               hit_any;
    logic [IDXW-1:0]    hit_idx;
    logic               has_free;
    logic [IDXW-1:0]    free_idx;
    logic [IDXW-1:0]    victim;
    logic               fill_en;

    // Upper VA bits are checked upstream; the response page offset is zero.
    logic unused_bits;
    assign unused_bits = ^{lookup_addr[63:48], mmu_resp_addr[11:0]};

    // Scanning downwards leaves the lowest matching index in hit_idx.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (vpn[i] == lookup_addr[47:12])) begin
                hit_any = 1'b1;
                hit_idx = IDXW'(i);
            end
        end
    end

    assign lookup_hit   = lookup_valid & hit_any;
    assign lookup_paddr = lookup_hit ? {ppn[hit_idx], lookup_addr[11:0]} : 64'd0;
    assign lookup_perms = lookup_hit ? perms[hit_idx] : 8'd0;

    // Prefer the lowest free slot; only evict round-robin when full.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IDXW'(i);
            end
        end
    end

    assign victim  = has_free ? free_idx : rr_ptr;
    assign fill_en = (state == WALK) && mmu_resp_valid && !flush;

    assign busy          = (state != IDLE);
    assign mmu_req_valid = busy;
    assign mmu_req_addr  = busy ? miss_va : 64'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            valid   <= '0;
            rr_ptr  <= '0;
            miss_va <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (lookup_valid && !hit_any) begin
                        miss_va <= lookup_addr;
                        state   <= WALK;
                    end
                end
                WALK: begin
                    if (flush) begin
                        // A response in the flush cycle is dropped, not filled.
                        valid <= '0;
                        state <= mmu_resp_valid ? IDLE : DRAIN;
                    end else if (mmu_resp_valid) begin
                        valid[victim] <= 1'b1;
                        if (!has_free) begin
                            rr_ptr <= rr_ptr + IDXW'(1);
                        end
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        valid <= '0;
                    end
                    if (mmu_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry payload needs no reset: it is only visible through a valid bit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            vpn[victim]   <= miss_va[47:12];
            ppn[victim]   <= mmu_resp_addr[63:12];
            perms[victim] <= mmu_resp_perms;
        end
    end

endmodule

// File: tb/tb_tlb_cache.sv
// Bench for tlb_cache: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_tlb_cache;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [63:0] lookup_addr = 64'd0;
    logic        lookup_hit;
    logic [63:0] lookup_paddr;
    logic [7:0]  lookup_perms;
    logic        busy;
    logic        flush = 1'b0;
    logic        mmu_req_valid;
    logic [63:0] mmu_req_addr;
    logic        mmu_resp_valid = 1'b0;
    logic [63:0] mmu_resp_addr = 64'd0;
    logic [7:0]  mmu_resp_perms = 8'd0;

    tlb_cache #(.ENTRIES(N)) dut (
        .clk(clk),
        .reset(reset),
        .lookup_valid(lookup_valid),
        .lookup_addr(lookup_addr),
        .lookup_hit(lookup_hit),
        .lookup_paddr(lookup_paddr),
        .lookup_perms(lookup_perms),
        .busy(busy),
        .flush(flush),
        .mmu_req_valid(mmu_req_valid),
        .mmu_req_addr(mmu_req_addr),
        .mmu_resp_valid(mmu_resp_valid),
        .mmu_resp_addr(mmu_resp_addr),
        .mmu_resp_perms(mmu_resp_perms)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int wcnt = 0;
    int walk_lat = 6;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_v    [N];
    logic [35:0] m_vpn  [N];
    logic [51:0] m_ppn  [N];
    logic [7:0]  m_perm [N];
    int          m_rr = 0;
    bit          m_pend = 1'b0;
    bit          m_disc = 1'b0;
    logic [63:0] m_va = 64'd0;

    function automatic int m_find(input logic [63:0] a);
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_vpn[i] == a[47:12]) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    endtask

    task automatic m_install();
        int v;
        v = -1;
        for (int i = 0; i < N; i++)
            if (!m_v[i] && v < 0) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % N;
        end
        m_v[v]    = 1'b1;
        m_vpn[v]  = m_va[47:12];
        m_ppn[v]  = mmu_resp_addr[63:12];
        m_perm[v] = mmu_resp_perms;
    endtask

    task automatic m_step();
        int h;
        if (!reset) begin
            m_clear();
            m_rr = 0;
            m_pend = 1'b0;
            m_disc = 1'b0;
            m_va = 64'd0;
        end else begin
            h = lookup_valid ? m_find(lookup_addr) : -1;
            if (!m_pend) begin
                if (flush) m_clear();
                else if (lookup_valid && h < 0) begin
                    m_pend = 1'b1;
                    m_disc = 1'b0;
                    m_va = lookup_addr;
                end
            end else if (flush) begin
                m_clear();
                if (mmu_resp_valid) m_pend = 1'b0;
                else m_disc = 1'b1;
            end else if (mmu_resp_valid) begin
                if (!m_disc) m_install();
                m_pend = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        m_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        int h;
        @(negedge clk);
        if (chk_en) begin
            h = lookup_valid ? m_find(lookup_addr) : -1;
            chk("m_hit", 64'(lookup_hit), 64'(h >= 0));
            chk("m_paddr", lookup_paddr, (h >= 0) ? {m_ppn[h], lookup_addr[11:0]} : 64'd0);
            chk("m_perms", 64'(lookup_perms), (h >= 0) ? 64'(m_perm[h]) : 64'd0);
            chk("m_busy", 64'(busy), 64'(m_pend));
            chk("m_req_valid", 64'(mmu_req_valid), 64'(m_pend));
            chk("m_req_addr", mmu_req_addr, m_pend ? m_va : 64'd0);
        end
    end

    // ---------------- walker and stimulus helpers ----------------
    function automatic logic [63:0] map_pa(input logic [63:0] va);
        if (va[47:12] == 36'h7FFF12345) return 64'h8000_3000;
        return {16'h0012, va[47:12] ^ 36'h0_0F0F_0F0F, 12'h000};
    endfunction

    function automatic logic [7:0] map_perm(input logic [63:0] va);
        if (va[47:12] == 36'h7FFF12345) return 8'hCF;
        return va[19:12] ^ 8'h3C;
    endfunction

    function automatic logic [63:0] page(input int i);
        return {16'h0000, 36'(32'h100 + i), 12'h000};
    endfunction

    // One clock; the walker answers walk_lat cycles after the request rises.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!mmu_req_valid) begin
            wcnt = 0;
            mmu_resp_valid = 1'b0;
            mmu_resp_addr = {$urandom, $urandom} & ~64'hFFF;
        end else begin
            mmu_resp_valid = (wcnt >= walk_lat);
            if (wcnt >= walk_lat) begin
                mmu_resp_addr  = map_pa(mmu_req_addr);
                mmu_resp_perms = map_perm(mmu_req_addr);
            end
            wcnt++;
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mmu_req_valid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_req_timeout", 64'(mmu_req_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_fill(input logic [63:0] va);
        lookup_valid = 1'b1;
        lookup_addr = va;
        tick();
        lookup_valid = 1'b0;
        wait_idle();
    endtask

    task automatic look(input logic [63:0] va, input bit exp, input string name);
        lookup_valid = 1'b1;
        lookup_addr = va;
        #2;
        chk(name, 64'(lookup_hit), 64'(exp));
        tick();
        lookup_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        chk("rst_hit", 64'(lookup_hit), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_valid", 64'(mmu_req_valid), 64'd0);
        chk("rst_req_addr", mmu_req_addr, 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // Basic miss, walk of 6 cycles, then hit.
        lookup_valid = 1'b1;
        lookup_addr = 64'h0000_7FFF_1234_5678;
        #2 chk("t1_first_hit", 64'(lookup_hit), 64'd0);
        tick();
        lookup_valid = 1'b0;
        #2;
        chk("t1_req_valid", 64'(mmu_req_valid), 64'd1);
        chk("t1_req_addr", mmu_req_addr, 64'h0000_7FFF_1234_5678);
        n = 0;
        while (!mmu_resp_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        lookup_valid = 1'b1;
        lookup_addr = 64'h0000_7FFF_1234_5678;
        #2;
        chk("t1_hit", 64'(lookup_hit), 64'd1);
        chk("t1_paddr", lookup_paddr, 64'h8000_3678);
        chk("t1_perms", 64'(lookup_perms), 64'hCF);
        chk("t1_busy", 64'(busy), 64'd0);
        tick();
        lookup_valid = 1'b0;

        // Empty the cache, fill 9 pages: the 9th evicts entry 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) begin
            walk_lat = int'($urandom_range(0, 5));
            do_fill(page(i));
        end
        walk_lat = 6;
        lookup_valid = 1'b1;
        lookup_addr = page(9);
        tick();
        lookup_valid = 1'b0;
        wait_req();
        look(page(0), 1'b0, "rr_page0_evicted");
        look(page(1), 1'b1, "rr_page1_resident");
        look(page(8), 1'b1, "rr_page8_resident");
        wait_idle();

        // Hit-under-miss; also confirms the 10th fill replaced entry 1.
        lookup_valid = 1'b1;
        lookup_addr = page(10);
        tick();
        lookup_valid = 1'b0;
        wait_req();
        look(page(1), 1'b0, "rr_page1_evicted");
        look(page(3), 1'b1, "hum_resident_hit");
        lookup_valid = 1'b1;
        lookup_addr = page(11);
        #2;
        chk("hum_miss_hit", 64'(lookup_hit), 64'd0);
        chk("hum_req_addr", mmu_req_addr, page(10));
        tick();
        lookup_valid = 1'b0;
        #2 chk("hum_req_addr_held", mmu_req_addr, page(10));
        wait_idle();

        // Flush 2 cycles before the response: response discarded.
        lookup_valid = 1'b1;
        lookup_addr = page(12);
        tick();
        lookup_valid = 1'b0;
        wait_req();
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2 chk("fl_drain_busy", 64'(busy), 64'd1);
        wait_idle();
        chk("fl_idle", 64'(busy), 64'd0);
        look(page(3), 1'b0, "fl_resident_gone");
        look(page(12), 1'b0, "fl_walked_page_miss");
        look(page(10), 1'b0, "fl_page10_gone");
        wait_idle();

        // Flush in the same cycle as the response: no fill.
        lookup_valid = 1'b1;
        lookup_addr = page(13);
        tick();
        lookup_valid = 1'b0;
        wait_req();
        n = 0;
        while (!mmu_resp_valid && n < 20) begin
            tick();
            n++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2 chk("fl_same_busy", 64'(busy), 64'd0);
        look(page(13), 1'b0, "fl_same_no_fill");
        wait_idle();

        // Asynchronous reset during a walk.
        lookup_valid = 1'b1;
        lookup_addr = page(14);
        tick();
        lookup_valid = 1'b0;
        wait_req();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("ar_req_valid", 64'(mmu_req_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_req_addr", mmu_req_addr, 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        mmu_resp_valid = 1'b1;
        mmu_resp_addr = map_pa(page(14));
        mmu_resp_perms = map_perm(page(14));
        tick();
        look(page(13), 1'b0, "ar_prior_page_miss");
        look(page(14), 1'b0, "ar_late_resp_ignored");
        wait_idle();

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            lookup_valid = ($urandom_range(0, 3) != 0);
            lookup_addr = {16'($urandom), 36'(32'h200 + $urandom_range(0, 11)), 12'($urandom)};
            flush = ($urandom_range(0, 39) == 0);
            if (!busy) walk_lat = int'($urandom_range(0, 5));
            tick();
        end
        lookup_valid = 1'b0;
        flush = 1'b0;
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tlb_cache.md
Name: tlb_cache

Overview:
- Small fully-associative translation cache placed in front of the page-table walker. One instance serves the I-side and one the D-side.
- Each instance answers fetch/LSU virtual-address lookups combinationally on a hit.
- On a miss it issues a single walk request to the walker port and holds it stable until the walker responds.
- It then installs the translated 4 KiB page and its DAGUXWRV permission bits.

Parameters:
- ENTRIES, 8, number of TLB entries; power of two, >= 2.
- IDXW, $clog2(ENTRIES), entry index / round-robin pointer width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); all state clears immediately on assertion.
- lookup_valid  input  1  lookup request present this cycle.
- lookup_addr  input  64  virtual address to translate.
- lookup_hit  output  1  lookup_valid and a matching valid entry exist this cycle.
- lookup_paddr  output  64  {entry ppn[51:0], lookup_addr[11:0]}; 0 when not hit.
- lookup_perms  output  8  entry DAGUXWRV bits; 0 when not hit.
- busy  output  1  walk outstanding (state != IDLE).
- flush  input  1  invalidate all entries (sfence.vma); single-cycle pulse or level.
- mmu_req_valid  output  1  walk request to walker port.
- mmu_req_addr  output  64  virtual address to walk.
- mmu_resp_valid  input  1  walker result valid for this port.
- mmu_resp_addr  input  64  translated page address; bits [11:0] are zero, superpage bits already merged.
- mmu_resp_perms  input  8  DAGUXWRV of the leaf PTE.

Behaviour:
- Entry contents: valid bit, vpn[35:0] (VA[47:12]), ppn[51:0] (PA[63:12]), perms[7:0]. All valid bits clear on reset.
- Lookup is combinational: hit when lookup_valid and some valid entry has vpn == lookup_addr[47:12]. Hits are served in every state, including during a walk and in the cycle flush is asserted. Pre-flush contents apply that cycle.
- Duplicate matches cannot occur by construction. If they do, the lowest index wins.
- State machine states: IDLE, WALK, DRAIN.
- IDLE:
  - On lookup_valid with no hit and flush low, latch miss_va <= lookup_addr and go to WALK next cycle.
  - mmu_req_valid = 0.
- WALK:
  - mmu_req_valid = 1 and mmu_req_addr = miss_va, held constant every cycle until the response. The walker only validates its response while the request address is unchanged.
  - New misses are ignored: lookup_hit = 0 for them and no second request is issued. The requester retries.
  - On mmu_resp_valid with flush low: install {mmu_resp_addr[63:12], mmu_resp_perms, vpn = miss_va[47:12]} into the victim entry, set its valid bit, and go to IDLE.
  - The new entry hits from the following cycle onward, i.e. a miss-to-hit latency of walk latency + 1 cycle.
  - If flush is high while in WALK and mmu_resp_valid is low: clear all valid bits and go to DRAIN.
  - If flush and mmu_resp_valid are high in the same cycle: flush wins. Clear all entries, do not fill, go to IDLE.
- DRAIN:
  - Keep mmu_req_valid = 1 with miss_va until mmu_resp_valid, then discard the response and go to IDLE.
  - Further flushes re-clear the entries.
- Victim selection: the lowest-index invalid entry. If all entries are valid, use rr_ptr; rr_ptr increments mod ENTRIES only after a fill that used rr_ptr. rr_ptr resets to 0 and is unchanged by flush.
- flush in IDLE: clear all valid bits at the clock edge. A miss in the same cycle does not start a walk.
- Reset mid-walk: returns to IDLE and deasserts mmu_req_valid immediately (asynchronous). A walker response arriving afterwards is ignored.
- Reset values: lookup_hit 0, lookup_paddr 0, lookup_perms 0, busy 0, mmu_req_valid 0, mmu_req_addr 0. Internal state: rr_ptr 0, miss_va 0, all valid bits 0.
- mmu_req_addr = 0 whenever mmu_req_valid = 0.
- Bits VA[63:48] are not compared; canonicality is checked upstream.
- The valid perm bit (perms[0]) is stored as given; no filtering.

Test Plan:
- Reset, then lookup 0x0000_7FFF_1234_5678:
  - Required: lookup_hit = 0, and mmu_req_valid rises the next cycle with mmu_req_addr 0x7FFF_1234_5678.
  - Walker responds after 6 cycles with addr 0x8000_3000, perms 0xCF.
  - Required: one cycle after the response, lookup_hit = 1, lookup_paddr = 0x8000_3678, lookup_perms = 0xCF, busy = 0.
- Fill 8 distinct pages (entries 0..7), then miss a 9th:
  - Required: the 9th fill replaces entry 0 (the old page now misses) and a 10th miss replaces entry 1.
- Hit-under-miss:
  - Stimulus: while WALK is pending, look up a page already resident, then a different non-resident page.
  - Required: the resident page hits; the non-resident page gives lookup_hit = 0 and mmu_req_addr stays at the original miss_va.
- Flush during walk:
  - Stimulus: pulse flush 2 cycles before mmu_resp_valid.
  - Required: all previously resident pages miss; the response is discarded (the walked page still misses afterwards); state returns to IDLE.
  - Same-cycle variant: flush together with mmu_resp_valid gives no fill and busy = 0 the next cycle.
- Async reset:
  - Stimulus: assert reset low mid-clock during WALK.
  - Required: mmu_req_valid and busy fall immediately without waiting for a clock edge; after release, every prior page misses.
